// File: rtl/rc4_pkg.sv
// Shared RC4 constants and state encodings for the init, ksa and prga engines.
package rc4_pkg;

    localparam int BYTE_W    = 8;
    localparam int MEM_DEPTH = 256;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [1:0] {
        INIT_IDLE,
        INIT_FILL
    } init_state_t;

    typedef enum logic [2:0] {
        KSA_IDLE,
        KSA_RDI,
        KSA_RDJ,
        KSA_SWJ,
        KSA_SWI
    } ksa_state_t;

    typedef enum logic [3:0] {
        PRGA_IDLE,
        PRGA_LEN0,
        PRGA_LEN1,
        PRGA_RDI,
        PRGA_RDJ,
        PRGA_SWJ,
        PRGA_SWI,
        PRGA_RDP,
        PRGA_WRP
    } prga_state_t;

endpackage

// File: rtl/prga.sv
// RC4 keystream generator: walks and swaps S, XORs keystream with length-prefixed CT
// and writes length-prefixed PT. Six cycles per byte over single-port synchronous RAMs.
//
//  state | meaning
//  IDLE  | rdy=1, waiting for en
//  LEN0  | address CT[0] (length byte)
//  LEN1  | latch length, copy it to PT[0], init i/j/k
//  RDI   | address S[i]
//  RDJ   | capture si, advance j, address S[j]
//  SWJ   | capture sj, write S[j]=si
//  SWI   | write S[i]=sj
//  RDP   | address S[si+sj] and CT[k]
//  WRP   | write PT[k] = keystream ^ CT[k]
module prga
    import rc4_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        rdy,
    output logic [7:0]  s_addr,
    input  logic [7:0]  s_rddata,
    output logic [7:0]  s_wrdata,
    output logic        s_wren,
    output logic [7:0]  ct_addr,
    input  logic [7:0]  ct_rddata,
    output logic [7:0]  pt_addr,
    output logic [7:0]  pt_wrdata,
    output logic        pt_wren
);

    prga_state_t state_q, state_d;
    byte_t       i_q, i_d;
    byte_t       j_q, j_d;
    byte_t       k_q, k_d;
    byte_t       len_q, len_d;
    byte_t       si_q, si_d;
    byte_t       sj_q, sj_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PRGA_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            len_q   <= '0;
            si_q    <= '0;
            sj_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            len_q   <= len_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        len_d     = len_q;
        si_d      = si_q;
        sj_d      = sj_q;
        rdy       = 1'b0;
        s_addr    = '0;
        s_wrdata  = '0;
        s_wren    = 1'b0;
        ct_addr   = '0;
        pt_addr   = '0;
        pt_wrdata = '0;
        pt_wren   = 1'b0;

        unique case (state_q)
            PRGA_IDLE: begin
                rdy = 1'b1;
                if (en) state_d = PRGA_LEN0;
            end
            PRGA_LEN0: begin
                ct_addr = '0;
                state_d = PRGA_LEN1;
            end
            PRGA_LEN1: begin
                len_d     = ct_rddata;
                pt_addr   = '0;
                pt_wrdata = ct_rddata;
                pt_wren   = 1'b1;
                i_d       = 8'd1;
                j_d       = '0;
                k_d       = 8'd1;
                state_d   = (ct_rddata == 8'd0) ? PRGA_IDLE : PRGA_RDI;
            end
            PRGA_RDI: begin
                s_addr  = i_q;
                state_d = PRGA_RDJ;
            end
            PRGA_RDJ: begin
                si_d    = s_rddata;
                j_d     = j_q + s_rddata;
                s_addr  = j_q + s_rddata;
                state_d = PRGA_SWJ;
            end
            PRGA_SWJ: begin
                // sj is taken before either write lands, so i==j swaps to itself
                sj_d     = s_rddata;
                s_addr   = j_q;
                s_wrdata = si_q;
                s_wren   = 1'b1;
                state_d  = PRGA_SWI;
            end
            PRGA_SWI: begin
                s_addr   = i_q;
                s_wrdata = sj_q;
                s_wren   = 1'b1;
                state_d  = PRGA_RDP;
            end
            PRGA_RDP: begin
                s_addr  = si_q + sj_q;
                ct_addr = k_q;
                state_d = PRGA_WRP;
            end
            PRGA_WRP: begin
                pt_addr   = k_q;
                pt_wrdata = s_rddata ^ ct_rddata;
                pt_wren   = 1'b1;
                if (k_q == len_q) begin
                    state_d = PRGA_IDLE;
                end else begin
                    k_d     = k_q + 8'd1;
                    i_d     = i_q + 8'd1;
                    state_d = PRGA_RDI;
                end
            end
            default: state_d = PRGA_IDLE;
        endcase
    end

endmodule

// File: tb/tb_prga.sv
// Directed bench for prga with behavioural S/CT/PT RAMs and an RC4 reference model.
module tb_prga;

    logic       clk;
    logic       rst;
    logic       en;
    logic       rdy;
    logic [7:0] s_addr, s_rddata, s_wrdata;
    logic       s_wren;
    logic [7:0] ct_addr, ct_rddata;
    logic [7:0] pt_addr, pt_wrdata;
    logic       pt_wren;

    logic [7:0] s_mem  [256];
    logic [7:0] ct_mem [256];
    logic [7:0] pt_mem [256];
    logic [7:0] s_init [256];
    logic [7:0] ct_init[256];
    logic [7:0] ref_s  [256];
    logic [7:0] exp_pt [256];
    logic       load;
    int         s_wr_cnt;
    int         pt_wr_cnt;

    int checks   = 0;
    int failures = 0;

    prga dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rdy       (rdy),
        .s_addr    (s_addr),
        .s_rddata  (s_rddata),
        .s_wrdata  (s_wrdata),
        .s_wren    (s_wren),
        .ct_addr   (ct_addr),
        .ct_rddata (ct_rddata),
        .pt_addr   (pt_addr),
        .pt_wrdata (pt_wrdata),
        .pt_wren   (pt_wren)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM models; read returns pre-write contents.
    always @(posedge clk) begin
        if (load) begin
            for (int n = 0; n < 256; n++) begin
                s_mem[n]  <= s_init[n];
                ct_mem[n] <= ct_init[n];
                pt_mem[n] <= 8'hEE;
            end
            s_wr_cnt  <= 0;
            pt_wr_cnt <= 0;
        end else begin
            if (s_wren) begin
                s_mem[s_addr] <= s_wrdata;
                s_wr_cnt      <= s_wr_cnt + 1;
            end
            if (pt_wren) begin
                pt_mem[pt_addr] <= pt_wrdata;
                pt_wr_cnt       <= pt_wr_cnt + 1;
            end
        end
        s_rddata  <= s_mem[s_addr];
        ct_rddata <= ct_mem[ct_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_load();
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    // Pulses en for one cycle; optionally pulses it again at busy cycle pulse_at.
    task automatic run(input int pulse_at, output int cyc);
        en = 1'b1;
        @(posedge clk); #1;
        en  = 1'b0;
        cyc = 0;
        while (!rdy && cyc < 2000) begin
            en = (pulse_at != 0 && cyc == pulse_at);
            @(posedge clk); #1;
            cyc++;
        end
        en = 1'b0;
    endtask

    function automatic void identity_s();
        for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
    endfunction

    function automatic void ref_prga();
        logic [7:0] i, j, t, si, sj, len;
        ref_s     = s_init;
        exp_pt    = ct_init;
        len       = ct_init[0];
        exp_pt[0] = len;
        i = 8'd0;
        j = 8'd0;
        for (int n = 1; n <= int'(len); n++) begin
            i        = i + 8'd1;
            si       = ref_s[i];
            j        = j + si;
            sj       = ref_s[j];
            ref_s[i] = sj;
            ref_s[j] = si;
            t        = si + sj;
            exp_pt[n] = ref_s[t] ^ ct_init[n];
        end
    endfunction

    function automatic void ref_ksa();
        logic [7:0] j, tmp;
        logic [7:0] key [3];
        key[0] = 8'h00;
        key[1] = 8'h03;
        key[2] = 8'h3C;
        identity_s();
        j = 8'd0;
        for (int n = 0; n < 256; n++) begin
            j         = j + s_init[n] + key[n % 3];
            tmp       = s_init[n];
            s_init[n] = s_init[j];
            s_init[j] = tmp;
        end
    endfunction

    initial begin
        int cyc;
        int bad;
        logic seen [256];
        logic [7:0] hello [6];

        rst  = 1'b1;
        en   = 1'b0;
        load = 1'b0;
        identity_s();
        for (int n = 0; n < 256; n++) ct_init[n] = 8'h00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_rdy", rdy, 1);
        check("reset_s_wren", s_wren, 0);
        check("reset_pt_wren", pt_wren, 0);
        check("reset_s_addr", s_addr, 0);
        check("reset_pt_addr", {pt_addr, s_wrdata, pt_wrdata, ct_addr}, 0);
        rst = 1'b0;

        // Reset mid-run on the first S write (SWJ)
        ct_init[0] = 8'h03;
        do_load();
        en = 1'b1;
        @(posedge clk); #1;
        en  = 1'b0;
        cyc = 0;
        while (!s_wren && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("midrun_reach_swj", s_wren, 1);
        check("midrun_swj_addr", s_addr, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrun_rst_rdy", rdy, 1);
        check("midrun_rst_s_wren", s_wren, 0);
        check("midrun_rst_pt_wren", pt_wren, 0);
        check("midrun_rst_s_addr", s_addr, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero-length message
        identity_s();
        for (int n = 0; n < 256; n++) ct_init[n] = 8'h5A;
        ct_init[0] = 8'h00;
        do_load();
        run(0, cyc);
        check("len0_cycles", cyc, 2);
        check("len0_pt0", pt_mem[0], 8'h00);
        check("len0_pt1_untouched", pt_mem[1], 8'hEE);
        check("len0_pt_writes", pt_wr_cnt, 1);
        check("len0_s_writes", s_wr_cnt, 0);

        // Identity S, CT={01,00}
        identity_s();
        for (int n = 0; n < 256; n++) ct_init[n] = 8'h00;
        ct_init[0] = 8'h01;
        do_load();
        run(0, cyc);
        check("l1_cycles", cyc, 8);
        check("l1_pt0", pt_mem[0], 8'h01);
        check("l1_pt1", pt_mem[1], 8'h02);
        check("l1_pt2_untouched", pt_mem[2], 8'hEE);
        bad = 0;
        for (int n = 0; n < 256; n++) if (s_mem[n] !== 8'(n)) bad++;
        check("l1_s_unchanged", bad, 0);

        // Identity S, CT={02,00,00}
        ct_init[0] = 8'h02;
        do_load();
        run(0, cyc);
        check("l2_cycles", cyc, 14);
        check("l2_pt0", pt_mem[0], 8'h02);
        check("l2_pt1", pt_mem[1], 8'h02);
        check("l2_pt2", pt_mem[2], 8'h05);
        check("l2_s2", s_mem[2], 8'h03);
        check("l2_s3", s_mem[3], 8'h02);
        bad = 0;
        for (int n = 0; n < 256; n++) if (n != 2 && n != 3 && s_mem[n] !== 8'(n)) bad++;
        check("l2_s_rest", bad, 0);

        // Identity S, L=255, random data
        identity_s();
        ct_init[0] = 8'hFF;
        for (int n = 1; n < 256; n++) ct_init[n] = 8'($urandom_range(0, 255));
        ref_prga();
        do_load();
        run(0, cyc);
        check("l255_cycles", cyc, 1532);
        check("l255_pt0", pt_mem[0], 8'hFF);
        bad = 0;
        for (int n = 1; n < 256; n++) if (pt_mem[n] !== exp_pt[n]) bad++;
        check("l255_pt_data", bad, 0);
        bad = 0;
        for (int n = 0; n < 256; n++) if (s_mem[n] !== ref_s[n]) bad++;
        check("l255_s_final", bad, 0);
        for (int n = 0; n < 256; n++) seen[n] = 1'b0;
        for (int n = 0; n < 256; n++) seen[s_mem[n]] = 1'b1;
        bad = 0;
        for (int n = 0; n < 256; n++) if (!seen[n]) bad++;
        check("l255_s_permutation", bad, 0);

        // KSA key 00033C, decrypt "Hello", with a stray en while busy
        hello[0] = 8'h05;
        hello[1] = "H";
        hello[2] = "e";
        hello[3] = "l";
        hello[4] = "l";
        hello[5] = "o";
        ref_ksa();
        for (int n = 0; n < 256; n++) ct_init[n] = 8'h00;
        for (int n = 0; n < 6; n++) ct_init[n] = hello[n];
        ref_prga();
        for (int n = 0; n < 6; n++) ct_init[n] = exp_pt[n];
        do_load();
        run(5, cyc);
        check("hello_cycles", cyc, 32);
        for (int n = 0; n < 6; n++) check($sformatf("hello_pt%0d", n), pt_mem[n], hello[n]);
        check("hello_pt6_untouched", pt_mem[6], 8'hEE);
        @(posedge clk); #1;
        check("hello_no_restart", rdy, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
